// File: rtl/clock_en_bank.sv
// Bank of independent clock-enable tick generators with loadable divisors,
// one-shot mode and optional cascading from the previous channel's tick.
module clock_en_bank #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 17,
    parameter int DEFAULT_DIV = 75000
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic [NUM_CH-1:0]           EN,
    input  logic [NUM_CH-1:0]           CASCADE,
    input  logic [NUM_CH-1:0]           ONESHOT,
    input  logic [NUM_CH-1:0]           LOAD,
    input  logic [NUM_CH*DIV_WIDTH-1:0] DIV_IN,
    input  logic                        SYNC,
    output logic [NUM_CH-1:0]           DIV,
    output logic [NUM_CH-1:0]           BUSY
);

    logic [DIV_WIDTH-1:0] cnt_q [NUM_CH];
    logic [DIV_WIDTH-1:0] cnt_d [NUM_CH];
    logic [DIV_WIDTH-1:0] dvr_q [NUM_CH];
    logic [DIV_WIDTH-1:0] dvr_d [NUM_CH];
    logic [NUM_CH-1:0]    tick_q;
    logic [NUM_CH-1:0]    tick_d;
    logic [NUM_CH-1:0]    busy_q;
    logic [NUM_CH-1:0]    busy_d;

    logic [NUM_CH-1:0]    prev_tick;
    logic [NUM_CH-1:0]    casc;
    logic [NUM_CH-1:0]    en_eff;
    logic [NUM_CH-1:0]    run;

    // Channel 0 has no predecessor, so its cascade bit is masked off.
    assign prev_tick = tick_q << 1;
    assign casc      = CASCADE & ({NUM_CH{1'b1}} << 1);
    assign en_eff    = (casc & prev_tick) | (~casc & EN);
    assign run       = en_eff & (~ONESHOT | busy_q);

    always_comb begin
        tick_d = '0;
        busy_d = busy_q & ONESHOT;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            dvr_d[i] = dvr_q[i];
            if (LOAD[i]) begin
                dvr_d[i]  = DIV_IN[i*DIV_WIDTH +: DIV_WIDTH];
                cnt_d[i]  = '0;
                busy_d[i] = ONESHOT[i];
            end else if (SYNC) begin
                cnt_d[i] = '0;
            end else if (run[i]) begin
                // >= rather than == so any counter state still terminates
                if (cnt_q[i] >= dvr_q[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    if (ONESHOT[i]) begin
                        busy_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                dvr_q[i] <= DIV_WIDTH'(DEFAULT_DIV);
            end
            tick_q <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                dvr_q[i] <= dvr_d[i];
            end
            tick_q <= tick_d;
            busy_q <= busy_d;
        end
    end

    assign DIV  = tick_q;
    assign BUSY = busy_q;

endmodule

// File: doc/clock_en_bank.md
Name: clock_en_bank

Overview:
- Bank of NUM_CH independent clock-enable (tick) generators, each with a runtime-loadable divisor, a periodic or one-shot mode, and optional cascading from the previous channel's tick.
- Successor to the single fixed-divisor enable generator. Used as the common tick source for UART baud timing, debounce, LED/PWM refresh and timeout counters.
- All outputs are single-cycle, registered pulses in the CLOCK domain; it never gates or generates clocks.

Parameters:
- NUM_CH, 4: number of channels, 1..16.
- DIV_WIDTH, 17: divisor and counter width per channel, 1..32.
- DEFAULT_DIV, 75000: divisor loaded into every channel at reset; must fit in DIV_WIDTH.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (asserts asynchronously, deasserts synchronously upstream).
- EN  in  NUM_CH  per-channel count enable; a count happens only on cycles where the effective enable is high.
- CASCADE  in  NUM_CH  when bit i=1 (i>=1), channel i's effective enable is DIV[i-1] instead of EN[i]; bit 0 is ignored.
- ONESHOT  in  NUM_CH  per-channel mode: 0=periodic, 1=one-shot.
- LOAD  in  NUM_CH  per-channel load strobe: latch divisor, clear counter, arm one-shot.
- DIV_IN  in  NUM_CH*DIV_WIDTH  divisor values; channel i uses bits [i*DIV_WIDTH +: DIV_WIDTH].
- SYNC  in  1  global restart: clears all counters in the same cycle.
- DIV  out  NUM_CH  per-channel tick pulse, one cycle wide.
- BUSY  out  NUM_CH  one-shot armed or counting.

Behaviour:
- Reset (RESET=0): cnt=0, div_reg=DEFAULT_DIV, DIV=0, BUSY=0 on all channels, immediately and asynchronously.
- Effective enable: en_i = (CASCADE[i] && i>0) ? DIV[i-1] : EN[i]. The cascaded source is the registered DIV, so each cascaded stage adds 1 cycle of latency.
- Counting gate: run_i = en_i && (!ONESHOT[i] || BUSY[i]).
- Per-channel priority on each edge, highest first: LOAD, then SYNC, then run.
  - LOAD[i]: div_reg<=DIV_IN slice, cnt<=0, DIV[i]<=0, BUSY[i]<=ONESHOT[i].
  - SYNC (no LOAD): cnt<=0, DIV<=0; div_reg and BUSY unchanged.
  - run_i, cnt < div_reg: cnt<=cnt+1, DIV<=0.
  - run_i, cnt >= div_reg: cnt<=0, DIV<=1. In one-shot mode, also BUSY<=0.
  - Otherwise: cnt holds, DIV<=0.
- Period: with run_i continuously high from edge k, DIV is high for exactly one cycle after edge k+D (D = div_reg). It then repeats every D+1 enabled cycles.
  - D=0 gives DIV high every enabled cycle (continuous when EN is held).
  - Disabled cycles stretch the period; cnt is never lost.
- The >= compare is deliberate: it guarantees termination regardless of counter state. LOAD always clears cnt, so a new divisor applies from a clean count.
- ONESHOT=0 forces BUSY<=0 on the next edge. Switching periodic to one-shot without LOAD freezes the channel (BUSY=0) until the next LOAD.
- LOAD while armed re-arms and restarts the count; no tick is emitted for the aborted count.
- Terminal count and LOAD in the same cycle: LOAD wins, no tick.
- Counter arithmetic is DIV_WIDTH bits unsigned. cnt never exceeds div_reg, so no wrap. DIV_IN=2^DIV_WIDTH-1 gives period 2^DIV_WIDTH.
- Outputs depend only on registers; no combinational path from inputs to DIV or BUSY.
- Reset mid-count: all state is lost; the first post-reset period uses DEFAULT_DIV.

Test Plan:
- Reset, EN[0]=1 held, default DIV_WIDTH, LOAD[0] with DIV_IN=4 -> DIV[0] high 1 cycle on the 5th edge after LOAD, then every 5 cycles; 10 pulses counted over 50 cycles.
- EN[1] toggling 1,0,1,0 with divisor 3 -> DIV[1] pulse every 8 CLOCK cycles; cnt holds during EN=0 (checked via period).
- ONESHOT[2]=1, LOAD[2] with DIV_IN=2, EN=1 -> BUSY high for 3 cycles, one DIV[2] pulse, then BUSY=0 and no further pulses for 20 cycles; repeat LOAD on terminal cycle -> no pulse, fresh count of 3.
- CASCADE[1]=1, channel 0 divisor 1 and channel 1 divisor 2, EN[0]=1 -> DIV[0] every 2 cycles, DIV[1] every 6 cycles, each DIV[1] 1 cycle after a DIV[0].
- SYNC pulsed mid-count on all channels (divisors 4,6,9) -> all DIV outputs low that cycle; subsequent first pulses at +5, +7, +10 edges; simultaneous LOAD[3] with SYNC -> channel 3 takes new divisor.
- RESET=0 asserted asynchronously mid-period (between edges) -> DIV, BUSY go 0 immediately; after release with EN=1, first DIV[0] after 75001 enabled edges.
